// File: rtl/count_snapshot_fifo_pkg.sv
// count_snapshot_fifo_pkg: shared widths, defaults and snapshot record for the count snapshot FIFO
package count_snapshot_fifo_pkg;
  localparam int WRAP_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [WRAP_W_DEF-1:0] wrap;
    logic [3:0]            count;
  } snap_t;
  function automatic int snap_width(input int wrap_w);
    return wrap_w + 4;
  endfunction
endpackage

// File: rtl/count_snapshot_fifo_fifo.sv
// snapshot_fifo: synchronous FIFO with push/pop, level count and registered head (ports: clock, reset, flush, push, pop, din, dout, valid, level)
module snapshot_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_inc;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0] head_q, head_d;
  // head refills from the next slot on a pop, or takes din when the entry being pushed becomes the head
  always_comb begin
    rd_inc = rd_q + AW'(1);
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    head_d = flush ? head_q
           : (pop && level_q > LW'(1)) ? mem_q[rd_inc]
           : (push && level_q == LW'(pop)) ? din
           : head_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = head_q;
  assign level = level_q;
  assign valid = level_q != '0;
endmodule

// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: wrap-extended counter snapshots queued on capture (ports: clock, reset, enable, clear, counter_in, carry_in, capture, out_*, fifo_level, overflow)
module count_snapshot_fifo
  import count_snapshot_fifo_pkg::*;
#(
  parameter int WRAP_W = WRAP_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [3:0]                    counter_in,
  input  logic                          carry_in,
  input  logic                          capture,
  output logic [snap_width(WRAP_W)-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic                          overflow
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic carry_q, carry_d, carry_rise;
  logic [WRAP_W-1:0] wrap_q, wrap_d, wrap_next;
  logic overflow_q, overflow_d;
  logic full, push, pop;
  // the snapshot uses wrap_next so a carry edge in the capture cycle is already counted
  always_comb begin
    carry_d = carry_in;
    carry_rise = carry_in & ~carry_q;
    wrap_next = wrap_q + WRAP_W'(enable & carry_rise);
    wrap_d = clear ? '0 : wrap_next;
    pop = out_valid & out_ready & ~clear;
    full = fifo_level == LW'(DEPTH);
    push = capture & ~clear & (~full | pop);
    overflow_d = clear ? 1'b0 : overflow_q | (capture & full & ~pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      wrap_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
      wrap_q <= wrap_d;
      overflow_q <= overflow_d;
    end
  end
  snapshot_fifo #(.W(snap_width(WRAP_W)), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(clear),
    .push (push),
    .pop  (pop),
    .din  ({wrap_next, counter_in}),
    .dout (out_data),
    .valid(out_valid),
    .level(fifo_level)
  );
  assign overflow = overflow_q;
endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream consumer of the 4-bit counter stage; watches its count value and carry output in the same clock domain.
- Extends the count with a wrap counter that increments on each carry rising edge.
- On a capture pulse, stores the snapshot {wrap_count, counter_in} into a small FIFO, read through a valid/ready interface.
- Used to timestamp events against the counter chain without stalling it.

Parameters:
- WRAP_W, 8, width of the wrap (carry) counter; snapshot width is WRAP_W+4
- DEPTH, 4, FIFO entries; must be a power of two, at least 2

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  when low, carry edges are ignored (wrap_count holds); captures are still accepted
- clear  input  1  synchronous flush: empties FIFO, zeroes wrap_count, clears overflow
- counter_in  input  4  count value from the counter stage
- carry_in  input  1  carry output from the counter stage
- capture  input  1  one-cycle request to store a snapshot
- out_data  output  WRAP_W+4  head FIFO entry, {wrap[WRAP_W-1:0], count[3:0]}
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high
- fifo_level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- overflow  output  1  sticky; set when a capture is dropped because the FIFO is full

Behaviour:
- Reset (async, active-high):
  - wrap_count=0, carry_q=0, FIFO empty.
  - out_valid=0, out_data=0, fifo_level=0, overflow=0.
- Carry edge detection:
  - carry_q registers carry_in every cycle, regardless of enable.
  - carry_rise = carry_in & ~carry_q.
- Wrap counting:
  - If enable & carry_rise, wrap_count <= wrap_count+1, modulo 2^WRAP_W (wraps from all-ones to 0, no saturation, no flag).
  - A carry held high for several cycles counts once.
- Snapshot value:
  - snap = {wrap_next, counter_in}.
  - wrap_next is the incremented value when an enabled carry_rise occurs in the same cycle; otherwise it is the current wrap_count.
  - counter_in is sampled in the capture cycle.
- Push:
  - A capture with clear low pushes snap, unless the FIFO is full and no pop occurs that cycle.
  - A capture while full and not popping is dropped and sets overflow to 1.
  - A capture while full with a pop in the same cycle is accepted; level stays at DEPTH and overflow is not set.
- Pop: occurs when out_valid & out_ready; the head advances.
- Simultaneous push and pop when not empty: level unchanged, data order preserved.
- Latency:
  - Capture in cycle N gives out_valid=1 with that entry at the head in cycle N+1.
  - There is no combinational fall-through from capture to out_data.
- out_data:
  - Driven from the registered head entry.
  - Holds its value while out_valid & ~out_ready.
  - When empty, out_data holds its last value; consumers must qualify it with out_valid.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - fifo_level is a registered up/down count; out_valid = (fifo_level != 0).
- clear:
  - Priority over capture, pop and carry: next cycle FIFO empty, wrap_count=0, overflow=0.
  - carry_q still samples carry_in during clear.
- Reset asserted mid-operation: immediate return to reset values; queued data is lost.

Decomposition:
- Shared package holds:
  - snapshot width function WRAP_W+4;
  - default constants WRAP_W_DEF=8, DEPTH_DEF=4;
  - a typedef for the snapshot record {wrap, count}.
- One natural sub-module, snapshot_fifo: parameterised synchronous FIFO with push/pop, level and registered head, using the same clock and reset.
- The carry edge detection, wrap counter and overflow logic stay in the top module.

Test Plan:
- Reset, then apply 3 separate carry pulses with enable=1, then capture with counter_in=4'h7 → one cycle later out_valid=1, out_data={8'd3,4'h7}, fifo_level=1.
- carry_in held high for 5 cycles, enable=1 → wrap_count increments by exactly 1; repeat with enable=0 → no increment.
- Carry rising edge and capture in the same cycle, wrap_count=9, counter_in=4'h0 → stored entry {8'd10,4'h0}.
- out_ready=0 and 5 captures (DEPTH=4) → fifo_level=4, overflow=1 after the 5th, first 4 entries pop in order; then a capture while full with out_ready=1 in the same cycle → accepted, level stays 4, overflow unchanged.
- Drive 256 carry edges from wrap_count=0 → wrap_count returns to 0, next capture shows wrap field 8'd0.
- clear asserted with 2 entries queued, overflow=1, and a simultaneous capture → next cycle fifo_level=0, out_valid=0, overflow=0, wrap_count=0; the capture is discarded. An async reset pulse mid-stream → all outputs return to 0 immediately.
